// File: rtl/alu_link_pkg.sv
// Shared definitions for the UART ALU command link: FSM states and the
// on-wire byte order used by both the client and the responder.
package alu_link_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_TX,
        WAIT_RX
    } state_t;

    localparam int N_CMD_BYTES = 3;
    localparam int IDX_W       = $clog2(N_CMD_BYTES);

    typedef logic [IDX_W-1:0] byte_idx_t;

    localparam byte_idx_t BYTE_A    = byte_idx_t'(0);
    localparam byte_idx_t BYTE_B    = byte_idx_t'(1);
    localparam byte_idx_t BYTE_OP   = byte_idx_t'(2);
    localparam byte_idx_t LAST_BYTE = byte_idx_t'(N_CMD_BYTES - 1);

endpackage

// File: rtl/uart_alu_client.sv
// Host-side initiator for the UART ALU protocol: sends A, B, op as three
// bytes through uart_tx, then waits (bounded) for one result byte from uart_rx.
module uart_alu_client
    import alu_link_pkg::*;
#(
    parameter int NB_DATA        = 8,
    parameter int NB_ALU_OP      = 6,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_req_valid,
    input  logic [NB_DATA-1:0]   i_req_data_A,
    input  logic [NB_DATA-1:0]   i_req_data_B,
    input  logic [NB_ALU_OP-1:0] i_req_op,
    output logic                 o_req_ready,
    output logic [NB_DATA-1:0]   o_tx_data,
    output logic                 o_tx_start,
    input  logic                 i_tx_done,
    input  logic [NB_DATA-1:0]   i_rx_data,
    input  logic                 i_rx_done,
    output logic [NB_DATA-1:0]   o_res_data,
    output logic                 o_res_valid,
    output logic                 o_timeout,
    output logic                 o_busy
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t               state;
    state_t               state_next;
    logic [NB_DATA-1:0]   a_q;
    logic [NB_DATA-1:0]   b_q;
    logic [NB_ALU_OP-1:0] op_q;
    byte_idx_t            idx;
    logic [CNT_W-1:0]     cnt;
    logic                 last_byte;
    logic                 cnt_done;

    function automatic logic [NB_DATA-1:0] cmd_byte(
        input byte_idx_t            sel,
        input logic [NB_DATA-1:0]   a,
        input logic [NB_DATA-1:0]   b,
        input logic [NB_ALU_OP-1:0] op
    );
        case (sel)
            BYTE_A:  return a;
            BYTE_B:  return b;
            BYTE_OP: return NB_DATA'(op);
            default: return '0;
        endcase
    endfunction

    assign last_byte = (idx == LAST_BYTE);
    assign cnt_done  = (cnt == CNT_LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_req_valid) state_next = SEND;
            SEND:    state_next = WAIT_TX;
            WAIT_TX: if (i_tx_done) state_next = last_byte ? WAIT_RX : SEND;
            WAIT_RX: if (i_rx_done || cnt_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = (state == IDLE);
        o_busy      = (state != IDLE);
        o_tx_start  = (state == SEND);
    end

    // o_tx_data is loaded on entry to SEND so it stays stable through WAIT_TX.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            idx         <= '0;
            cnt         <= '0;
            o_tx_data   <= '0;
            o_res_data  <= '0;
            o_res_valid <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            o_res_valid <= 1'b0;
            o_timeout   <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        a_q       <= i_req_data_A;
                        b_q       <= i_req_data_B;
                        op_q      <= i_req_op;
                        idx       <= BYTE_A;
                        o_tx_data <= i_req_data_A;
                    end
                end
                WAIT_TX: begin
                    if (i_tx_done) begin
                        if (!last_byte) begin
                            idx       <= idx + 1'b1;
                            o_tx_data <= cmd_byte(idx + 1'b1, a_q, b_q, op_q);
                        end else begin
                            cnt <= '0;
                        end
                    end
                end
                WAIT_RX: begin
                    // A result arriving on the terminal count still wins.
                    if (i_rx_done) begin
                        o_res_data  <= i_rx_data;
                        o_res_valid <= 1'b1;
                    end else if (cnt_done) begin
                        o_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_client.sv
// Directed bench for uart_alu_client: a transaction-level protocol model is
// checked every cycle, plus hand-computed literal expectations per scenario.
module tb_uart_alu_client;

    localparam int TO_CYC = 1000;
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;

    logic       i_clk;
    logic       i_reset;
    logic       i_req_valid;
    logic [7:0] i_req_data_A;
    logic [7:0] i_req_data_B;
    logic [5:0] i_req_op;
    logic       o_req_ready;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       i_tx_done;
    logic [7:0] i_rx_data;
    logic       i_rx_done;
    logic [7:0] o_res_data;
    logic       o_res_valid;
    logic       o_timeout;
    logic       o_busy;

    uart_alu_client #(
        .NB_DATA(8),
        .NB_ALU_OP(6),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_req_valid(i_req_valid),
        .i_req_data_A(i_req_data_A),
        .i_req_data_B(i_req_data_B),
        .i_req_op(i_req_op),
        .o_req_ready(o_req_ready),
        .o_tx_data(o_tx_data),
        .o_tx_start(o_tx_start),
        .i_tx_done(i_tx_done),
        .i_rx_data(i_rx_data),
        .i_rx_done(i_rx_done),
        .o_res_data(o_res_data),
        .o_res_valid(o_res_valid),
        .o_timeout(o_timeout),
        .o_busy(o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- protocol model ----------------
    int         cyc = 0;
    bit         m_busy, m_send, m_wtx, m_wrx;
    int         m_sent;
    logic [7:0] m_bytes [3];
    logic [7:0] exp_byte = '0;
    logic [7:0] m_res = '0;
    int         exp_start = -1, exp_res = -1, exp_to = -1, deadline = -1;

    initial begin
        m_busy = 0; m_send = 0; m_wtx = 0; m_wrx = 0; m_sent = 0;
        forever begin
            @(posedge i_clk);
            cyc++;
            if (i_reset) begin
                m_busy = 0; m_send = 0; m_wtx = 0; m_wrx = 0;
                m_res = '0; exp_byte = '0;
                exp_start = -1; exp_res = -1; exp_to = -1;
            end else if (!m_busy) begin
                if (i_req_valid) begin
                    m_busy = 1; m_send = 1; m_sent = 0;
                    m_bytes[0] = i_req_data_A;
                    m_bytes[1] = i_req_data_B;
                    m_bytes[2] = {2'b00, i_req_op};
                    exp_byte = i_req_data_A;
                    exp_start = cyc;
                end
            end else if (m_send) begin
                m_send = 0; m_wtx = 1;
            end else if (m_wtx) begin
                if (i_tx_done) begin
                    m_wtx = 0;
                    m_sent++;
                    if (m_sent < 3) begin
                        exp_byte = m_bytes[m_sent];
                        exp_start = cyc;
                        m_send = 1;
                    end else begin
                        m_wrx = 1;
                        deadline = cyc + TO_CYC;
                    end
                end
            end else if (m_wrx) begin
                if (i_rx_done) begin
                    m_res = i_rx_data; exp_res = cyc; m_wrx = 0; m_busy = 0;
                end else if (cyc == deadline) begin
                    exp_to = cyc; m_wrx = 0; m_busy = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge i_clk);
            if (!i_reset) begin
                chk("ready", o_req_ready, !m_busy);
                chk("busy", o_busy, m_busy);
                chk("tx_start", o_tx_start, cyc == exp_start);
                if (m_busy && !m_wrx) chk("tx_data", o_tx_data, exp_byte);
                chk("res_valid", o_res_valid, cyc == exp_res);
                chk("timeout", o_timeout, cyc == exp_to);
                chk("res_data", o_res_data, m_res);
            end
        end
    end

    // ---------------- uart_tx emulator ----------------
    logic [7:0] tx_log [$];
    int n_started = 0, n_done = 0, t_done_edge = 0, pend = 0;

    initial begin
        i_tx_done = 1'b0;
        forever begin
            @(negedge i_clk);
            i_tx_done = 1'b0;
            if (i_reset) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        i_tx_done = 1'b1;
                        n_done++;
                        t_done_edge = cyc + 1;
                    end
                end
                if (o_tx_start) begin
                    pend = 3;
                    tx_log.push_back(o_tx_data);
                    n_started++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_req(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        int i;
        for (i = 0; i < 3000 && !o_req_ready; i++) begin
            @(negedge i_clk); #1;
        end
        chk("req_ready_wait", o_req_ready, 1);
        i_req_valid = 1'b1; i_req_data_A = a; i_req_data_B = b; i_req_op = op;
        @(negedge i_clk); #1;
        i_req_valid = 1'b0;
    endtask

    task automatic wait_cnt(input int which, input int target);
        for (int i = 0; i < 200; i++) begin
            if (((which == 0) ? n_done : n_started) >= target) break;
            @(negedge i_clk); #1;
        end
        chk("count_wait", ((which == 0) ? n_done : n_started) >= target, 1);
    endtask

    task automatic wait_sig(input int which, input int bound, output int t);
        t = -1;
        for (int i = 0; i < bound; i++) begin
            if ((which == 0 && o_res_valid) || (which == 1 && o_timeout) ||
                (which == 2 && o_tx_start)) begin
                t = cyc;
                break;
            end
            @(negedge i_clk); #1;
        end
        chk("sig_wait", t >= 0, 1);
    endtask

    task automatic rx_byte(input logic [7:0] d);
        @(negedge i_clk); #1;
        i_rx_done = 1'b1; i_rx_data = d;
        @(negedge i_clk); #1;
        i_rx_done = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ready", o_req_ready, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_tx_start", o_tx_start, 0);
        chk("rst_tx_data", o_tx_data, 8'h00);
        chk("rst_res_data", o_res_data, 8'h00);
        chk("rst_res_valid", o_res_valid, 0);
        chk("rst_timeout", o_timeout, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_chk);
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int b0, d0, t, t2, td;
        i_reset = 1'b1; i_req_valid = 1'b0; i_req_data_A = '0; i_req_data_B = '0;
        i_req_op = '0; i_rx_done = 1'b0; i_rx_data = '0;
        repeat (3) @(negedge i_clk);
        #1 chk_reset_outputs();
        #1 i_reset = 1'b0;
        @(negedge i_clk); #1;

        // nominal add: 5 + 3
        b0 = n_started; d0 = n_done;
        do_req(8'h05, 8'h03, OP_ADD);
        wait_cnt(0, d0 + 3);
        rx_byte(8'h08);
        wait_sig(0, 5, t);
        chk("nom_res", o_res_data, 8'h08);
        chk("nom_ready", o_req_ready, 1);
        chk("nom_byte0", tx_log[b0], 8'h05);
        chk("nom_byte1", tx_log[b0+1], 8'h03);
        chk("nom_byte2", tx_log[b0+2], 8'h20);

        // back-to-back: second request held valid while the first is in flight
        b0 = n_started; d0 = n_done;
        i_req_valid = 1'b1; i_req_data_A = 8'h10; i_req_data_B = 8'h20; i_req_op = OP_SUB;
        @(negedge i_clk); #1;
        i_req_data_A = 8'h0F; i_req_data_B = 8'h01; i_req_op = OP_AND;
        wait_cnt(0, d0 + 3);
        rx_byte(8'hF0);
        wait_sig(0, 5, t);
        chk("b2b_res1", o_res_data, 8'hF0);
        @(negedge i_clk); #1;
        i_req_valid = 1'b0;
        wait_sig(2, 5, t2);
        chk("b2b_accept_lat", t2 - t, 1);
        wait_cnt(0, d0 + 6);
        rx_byte(8'h01);
        wait_sig(0, 5, t);
        chk("b2b_res2", o_res_data, 8'h01);
        chk("b2b_b0", tx_log[b0], 8'h10);
        chk("b2b_b1", tx_log[b0+1], 8'h20);
        chk("b2b_b2", tx_log[b0+2], 8'h22);
        chk("b2b_b3", tx_log[b0+3], 8'h0F);
        chk("b2b_b4", tx_log[b0+4], 8'h01);
        chk("b2b_b5", tx_log[b0+5], 8'h24);

        // timeout: no result byte
        d0 = n_done;
        do_req(8'h07, 8'h02, OP_ADD);
        wait_cnt(0, d0 + 3);
        td = t_done_edge;
        wait_sig(1, TO_CYC + 100, t);
        chk("to_latency", t - td, TO_CYC);
        chk("to_res_kept", o_res_data, 8'h01);
        chk("to_ready", o_req_ready, 1);
        chk("to_no_valid", o_res_valid, 0);

        // result on the terminal timeout cycle wins
        d0 = n_done;
        do_req(8'h55, 8'h55, OP_ADD);
        wait_cnt(0, d0 + 3);
        td = t_done_edge;
        for (int i = 0; i < TO_CYC + 100 && cyc < td + TO_CYC - 1; i++) begin
            @(negedge i_clk); #1;
        end
        i_rx_done = 1'b1; i_rx_data = 8'hAA;
        @(negedge i_clk); #1;
        i_rx_done = 1'b0;
        chk("co_cycle", cyc, td + TO_CYC);
        chk("co_valid", o_res_valid, 1);
        chk("co_timeout", o_timeout, 0);
        chk("co_res", o_res_data, 8'hAA);

        // stray rx byte during WAIT_TX of byte B
        b0 = n_started; d0 = n_done;
        do_req(8'h10, 8'h01, OP_OR);
        wait_cnt(1, b0 + 2);
        rx_byte(8'h55);
        chk("stray_no_valid", o_res_valid, 0);
        wait_cnt(0, d0 + 3);
        rx_byte(8'h11);
        wait_sig(0, 5, t);
        chk("stray_res", o_res_data, 8'h11);

        // asynchronous reset during WAIT_TX of byte B
        b0 = n_started;
        do_req(8'h21, 8'h22, OP_ADD);
        wait_cnt(1, b0 + 2);
        @(negedge i_clk); #2;
        i_reset = 1'b1;
        #1 chk_reset_outputs();
        repeat (2) @(negedge i_clk);
        #2 i_reset = 1'b0;
        b0 = n_started; d0 = n_done;
        do_req(8'h33, 8'h44, OP_ADD);
        wait_cnt(1, b0 + 1);
        chk("rst_first_byte", tx_log[b0], 8'h33);
        wait_cnt(0, d0 + 3);
        rx_byte(8'h77);
        wait_sig(0, 5, t);
        chk("rst_res", o_res_data, 8'h77);

        repeat (3) @(negedge i_clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_alu_client.md
Name: uart_alu_client

Overview:
Host-side initiator for the UART ALU command protocol; it drives the opposite end from the on-chip command responder.
- Accepts one request (A, B, op) on a valid/ready handshake.
- Serializes the request as three bytes through a uart_tx instance, then waits for one result byte from a uart_rx instance.
- Returns the result, or flags a timeout.
- Used in loopback benches and on a second board to exercise the ALU link.

Parameters:
- NB_DATA, 8, data/operand width; equals UART byte width.
- NB_ALU_OP, 6, opcode width; must be <= NB_DATA.
- TIMEOUT_CYCLES, 2_000_000, clocks to wait for the result byte after the opcode byte completes (20 ms at 100 MHz).

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_req_valid  in  1  request present.
- i_req_data_A  in  NB_DATA  operand A.
- i_req_data_B  in  NB_DATA  operand B.
- i_req_op  in  NB_ALU_OP  ALU opcode.
- o_req_ready  out  1  client idle; request accepted when valid && ready.
- o_tx_data  out  NB_DATA  byte to uart_tx.
- o_tx_start  out  1  one-cycle start pulse to uart_tx.
- i_tx_done  in  1  uart_tx byte-complete pulse.
- i_rx_data  in  NB_DATA  byte from uart_rx.
- i_rx_done  in  1  uart_rx byte-valid pulse.
- o_res_data  out  NB_DATA  ALU result; held until the next result.
- o_res_valid  out  1  one-cycle pulse, result received.
- o_timeout  out  1  one-cycle pulse, no result within TIMEOUT_CYCLES.
- o_busy  out  1  transaction in progress (inverse of o_req_ready).

Behaviour:
- Reset values:
  - State IDLE.
  - o_req_ready=1, o_busy=0.
  - o_tx_start=0, o_tx_data=0.
  - o_res_data=0, o_res_valid=0, o_timeout=0.
  - Byte index=0, timeout counter=0.
- Byte order on the wire: A, then B, then op. The op byte is zero-extended to NB_DATA bits.
- States:
  - IDLE: ready=1. On valid&&ready, register A/B/op and go to SEND with index=0.
  - SEND: drive o_tx_data = byte[index], assert o_tx_start for exactly one cycle, go to WAIT_TX.
  - WAIT_TX: hold o_tx_data stable. On i_tx_done:
    - if index<2: index+1, go to SEND;
    - else: clear the counter, go to WAIT_RX.
  - WAIT_RX: on i_rx_done, register i_rx_data into o_res_data, pulse o_res_valid the next cycle, go to IDLE. Otherwise increment the counter; on reaching TIMEOUT_CYCLES-1, pulse o_timeout and go to IDLE. o_res_data is unchanged on timeout.
- Latency:
  - Request acceptance to first o_tx_start: 1 cycle.
  - tx_done to next tx_start: 1 cycle.
  - rx_done to o_res_valid: 1 cycle.
  - ready re-asserts in the same cycle as o_res_valid/o_timeout.
- i_rx_done outside WAIT_RX (stray or early byte) is ignored; no state change.
- If i_rx_done and the timeout terminal count coincide, the result wins: o_res_valid=1, o_timeout=0.
- i_tx_done outside WAIT_TX is ignored.
- i_req_valid while busy is ignored; the request stays pending upstream.
- A new request may be accepted the cycle after returning to IDLE.
- Reset mid-transaction returns immediately to reset values. No partial byte tracking is kept, and the bench must also reset the UART.
- Counter width: $clog2(TIMEOUT_CYCLES); no wrap is possible because the count stops at the terminal value.

Decomposition:
- Shared package alu_link_pkg:
  - state encoding localparams (IDLE, SEND, WAIT_TX, WAIT_RX);
  - BYTE_A=0, BYTE_B=1, BYTE_OP=2;
  - N_CMD_BYTES=3.
- The responder should import the same byte-order constants.
- No sub-module; the timeout counter stays inline.
- A top-level loopback wrapper (outside this spec) instantiates baudRateGen, uart_tx and uart_rx around this block.

Test Plan:
- Nominal add:
  - Stimulus: A=8'h05, B=8'h03, op=ADD, bench responder returns 8'h08.
  - Required: tx bytes 05, 03, then the ADD code zero-extended; o_res_valid pulse with o_res_data=8'h08; ready back high.
- Back-to-back:
  - Stimulus: second request presented continuously with valid=1.
  - Required: accepted exactly one cycle after the first o_res_valid; no byte reordering.
- Timeout (TIMEOUT_CYCLES=1000):
  - Stimulus: no rx_done after the op byte.
  - Required: o_timeout pulses exactly 1000 cycles after the third tx_done; o_res_data unchanged; ready=1.
- Coincidence:
  - Stimulus: rx_done=8'hAA on the terminal timeout cycle.
  - Required: o_res_valid=1, o_res_data=8'hAA, o_timeout=0.
- Stray rx:
  - Stimulus: rx_done=8'h55 during WAIT_TX of byte B.
  - Required: ignored; the subsequent real result 8'h11 is reported.
- Reset mid-op:
  - Stimulus: assert i_reset while in WAIT_TX of byte B.
  - Required: all outputs at reset values within the same cycle (asynchronous); the next request sends A first.
